// File: rtl/text_console_ctrl.sv
// Terminal-style writer for the word-organised VGA text RAM: accepts a byte
// stream, tracks the cursor, and performs byte-lane writes, hardware scroll and clear.
module text_console_ctrl #(
  parameter int unsigned COLS  = 70,
  parameter int unsigned ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

  localparam int unsigned AW = 12;
  localparam logic [AW-1:0] CLEAR_LAST  = AW'((ROWS * COLS + 3) / 4 - 1);
  localparam logic [AW-1:0] SCROLL_LAST = AW'((ROWS - 1) * COLS - 1);
  localparam logic [AW-1:0] SCREEN_LAST = AW'(ROWS * COLS - 1);
  localparam logic [4:0]    ROW_LAST    = 5'(ROWS - 1);
  localparam logic [6:0]    COL_LAST    = 7'(COLS - 1);

  typedef enum logic [2:0] {CLEAR, IDLE, PUT, SCROLL_RD, SCROLL_WR, SCROLL_CLR} state_t;

  state_t        state, state_next;
  logic [AW-1:0] ptr, ptr_next;
  logic [4:0]    row_next;
  logic [6:0]    col_next;
  logic [7:0]    put_char, put_char_next;
  logic          put_adv, put_adv_next;
  logic [AW-1:0] cur_addr, src_addr;
  logic [7:0]    rd_byte;

  assign cur_addr = AW'(cursor_row) * AW'(COLS) + AW'(cursor_col);
  assign src_addr = ptr + AW'(COLS);

  // Byte lane of the scroll source, read back one cycle after SCROLL_RD
  always_comb begin
    case (src_addr[1:0])
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      ptr        <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      put_char   <= BLANK;
      put_adv    <= 1'b0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      cursor_row <= row_next;
      cursor_col <= col_next;
      put_char   <= put_char_next;
      put_adv    <= put_adv_next;
    end
  end

  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    row_next      = cursor_row;
    col_next      = cursor_col;
    put_char_next = put_char;
    put_adv_next  = put_adv;
    case (state)
      CLEAR: begin
        ptr_next = ptr + AW'(1);
        if (ptr == CLEAR_LAST) begin
          state_next = IDLE;
          ptr_next   = '0;
          row_next   = '0;
          col_next   = '0;
        end
      end
      IDLE: begin
        if (ch_valid) begin
          if (ch_data >= 8'h20 && ch_data <= 8'h7E) begin
            state_next    = PUT;
            put_char_next = ch_data;
            put_adv_next  = 1'b1;
          end else begin
            case (ch_data)
              8'h0A: begin
                col_next = '0;
                if (cursor_row == ROW_LAST) begin
                  state_next = SCROLL_RD;
                  ptr_next   = '0;
                end else begin
                  row_next = cursor_row + 5'd1;
                end
              end
              8'h0D: col_next = '0;
              8'h08: begin
                // Cursor moves now; PUT then blanks the new position without advancing
                if (cursor_col != 7'd0) begin
                  col_next      = cursor_col - 7'd1;
                  state_next    = PUT;
                  put_char_next = BLANK;
                  put_adv_next  = 1'b0;
                end else if (cursor_row != 5'd0) begin
                  row_next      = cursor_row - 5'd1;
                  col_next      = COL_LAST;
                  state_next    = PUT;
                  put_char_next = BLANK;
                  put_adv_next  = 1'b0;
                end
              end
              8'h0C: begin
                state_next = CLEAR;
                ptr_next   = '0;
              end
              default: ;
            endcase
          end
        end
      end
      PUT: begin
        state_next = IDLE;
        if (put_adv) begin
          if (cursor_col == COL_LAST) begin
            col_next = '0;
            if (cursor_row == ROW_LAST) begin
              state_next = SCROLL_RD;
              ptr_next   = '0;
            end else begin
              row_next = cursor_row + 5'd1;
            end
          end else begin
            col_next = cursor_col + 7'd1;
          end
        end
      end
      SCROLL_RD: state_next = SCROLL_WR;
      SCROLL_WR: begin
        ptr_next   = ptr + AW'(1);
        state_next = (ptr == SCROLL_LAST) ? SCROLL_CLR : SCROLL_RD;
      end
      SCROLL_CLR: begin
        ptr_next = ptr + AW'(1);
        if (ptr == SCREEN_LAST) begin
          state_next = IDLE;
          ptr_next   = '0;
        end
      end
      default: begin
        state_next = CLEAR;
        ptr_next   = '0;
      end
    endcase
  end

  // Memory strobes are forced idle while reset is held
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    ch_ready  = (state == IDLE);
    busy      = (state != IDLE);
    if (!reset) begin
      case (state)
        CLEAR: begin
          mem_we    = 1'b1;
          mem_addr  = ptr[9:0];
          mem_be    = 4'hF;
          mem_wdata = {4{BLANK}};
        end
        PUT: begin
          mem_we    = 1'b1;
          mem_addr  = cur_addr[11:2];
          mem_be    = 4'b0001 << cur_addr[1:0];
          mem_wdata = {4{put_char}};
        end
        SCROLL_RD: begin
          mem_re   = 1'b1;
          mem_addr = src_addr[11:2];
        end
        SCROLL_WR: begin
          mem_we    = 1'b1;
          mem_addr  = ptr[11:2];
          mem_be    = 4'b0001 << ptr[1:0];
          mem_wdata = {4{rd_byte}};
        end
        SCROLL_CLR: begin
          mem_we    = 1'b1;
          mem_addr  = ptr[11:2];
          mem_be    = 4'b0001 << ptr[1:0];
          mem_wdata = {4{BLANK}};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: text RAM model plus a character-level screen/cursor
// reference, directed scenarios and a randomized character stream.
module tb_text_console_ctrl;

  localparam int NB = 2100;
  localparam int NW = 525;

  logic        clk, reset, ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready, mem_we, mem_re, busy;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;

  logic [31:0] ram [0:NW-1];
  logic        seed_we;
  logic [9:0]  seed_addr;
  logic [31:0] seed_data;

  logic [7:0]  screen [0:NB-1];
  int mrow, mcol;
  int n_cmp, n_fail;
  int p_busy, p_nwr, p_first_we, p_overlap;
  bit p_timeout;
  logic [9:0]  p_addr;
  logic [3:0]  p_be;
  logic [31:0] p_wdata;
  int c_cyc, c_nw, c_bad;

  text_console_ctrl #(.COLS(70), .ROWS(30), .BLANK(8'h20)) dut (
    .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(ch_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Text RAM: byte-enable writes, read data one cycle after mem_re, garbage otherwise
  always @(posedge clk) begin
    if (seed_we) ram[seed_addr] <= seed_data;
    else if (mem_we && mem_addr < 10'(NW))
      for (int k = 0; k < 4; k++)
        if (mem_be[k]) ram[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
    mem_rdata <= mem_re ? ram[mem_addr] : 32'($urandom);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ram_byte(input int b);
    logic [31:0] w;
    w = ram[b / 4];
    return w[8*(b % 4) +: 8];
  endfunction

  function automatic int screen_diff();
    int d = 0;
    for (int b = 0; b < NB; b++) if (ram_byte(b) !== screen[b]) d++;
    return d;
  endfunction

  function automatic logic [7:0] rand_char();
    logic [7:0] oth [0:6];
    int r;
    oth = '{8'h00, 8'h01, 8'h09, 8'h1B, 8'h7F, 8'h80, 8'hFF};
    r = $urandom_range(0, 99);
    if (r < 70) return 8'($urandom_range(32, 126));
    if (r < 76) return 8'h0A;
    if (r < 81) return 8'h0D;
    if (r < 91) return 8'h08;
    if (r < 93) return 8'h0C;
    return oth[$urandom_range(0, 6)];
  endfunction

  task automatic model_blank_all();
    for (int b = 0; b < NB; b++) screen[b] = 8'h20;
    mrow = 0;
    mcol = 0;
  endtask

  task automatic model_scroll();
    for (int b = 0; b < 2030; b++) screen[b] = screen[b + 70];
    for (int b = 2030; b < NB; b++) screen[b] = 8'h20;
  endtask

  // Terminal semantics of one character; returns busy cycles and word writes it costs
  task automatic model_char(input logic [7:0] c, output int eb, output int ew);
    eb = 0;
    ew = 0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      screen[mrow * 70 + mcol] = c;
      eb = 1; ew = 1;
      mcol++;
      if (mcol == 70) begin mcol = 0; mrow++; end
      if (mrow == 30) begin mrow = 29; model_scroll(); eb += 4130; ew += 2100; end
    end else if (c == 8'h0A) begin
      mcol = 0;
      if (mrow == 29) begin model_scroll(); eb = 4130; ew = 2100; end
      else mrow++;
    end else if (c == 8'h0D) begin
      mcol = 0;
    end else if (c == 8'h08) begin
      if (mcol > 0 || mrow > 0) begin
        if (mcol > 0) mcol--;
        else begin mrow--; mcol = 69; end
        screen[mrow * 70 + mcol] = 8'h20;
        eb = 1; ew = 1;
      end
    end else if (c == 8'h0C) begin
      model_blank_all();
      eb = 525; ew = 525;
    end
  endtask

  task automatic push(input logic [7:0] c);
    int t;
    p_busy = 0; p_nwr = 0; p_first_we = -1; p_overlap = 0; p_timeout = 0;
    p_addr = '0; p_be = '0; p_wdata = '0;
    @(negedge clk); ch_valid = 1'b1; ch_data = c; #2;
    t = 0;
    while (!ch_ready && t < 10000) begin @(negedge clk); #2; t++; end
    if (!ch_ready) p_timeout = 1;
    @(negedge clk); ch_valid = 1'b0; ch_data = 8'($urandom); #2;
    while (!ch_ready && p_busy < 10000) begin
      if (mem_we) begin
        if (p_first_we < 0) p_first_we = p_busy;
        p_nwr++; p_addr = mem_addr; p_be = mem_be; p_wdata = mem_wdata;
      end
      if (mem_we && mem_re) p_overlap++;
      p_busy++;
      @(negedge clk); #2;
    end
    if (!ch_ready) p_timeout = 1;
  endtask

  task automatic push_m(input logic [7:0] c);
    int eb, ew;
    push(c);
    model_char(c, eb, ew);
  endtask

  task automatic watch_clear();
    c_cyc = 0; c_nw = 0; c_bad = 0;
    while (!ch_ready && c_cyc < 2000) begin
      if (mem_we) begin
        c_nw++;
        if (mem_addr !== 10'(c_cyc) || mem_be !== 4'hF || mem_wdata !== 32'h20202020) c_bad++;
      end else c_bad++;
      c_cyc++;
      @(negedge clk); #2;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ch_valid = 1'b0; ch_data = 8'h00; seed_we = 1'b0;
    seed_addr = '0; seed_data = '0;
    repeat (3) @(negedge clk);
    #2;
    n_cmp++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin n_fail++; $display("FAIL rst_strobes: got we=%b re=%b required 0 0", mem_we, mem_re); end
    n_cmp++; if (mem_be !== 4'h0 || mem_addr !== 10'h0) begin n_fail++; $display("FAIL rst_addr_be: got addr=%0d be=%h required 0 0", mem_addr, mem_be); end
    n_cmp++; if (ch_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_ready_busy: got %b %b required 0 1", ch_ready, busy); end
    n_cmp++; if (cursor_row !== 5'd0 || cursor_col !== 7'd0) begin n_fail++; $display("FAIL rst_cursor: got %0d,%0d required 0,0", cursor_row, cursor_col); end
    @(negedge clk); reset = 1'b0; #2;
    watch_clear();
    model_blank_all();
    n_cmp++; if (c_cyc !== 525 || c_nw !== 525 || c_bad !== 0) begin n_fail++; $display("FAIL clear_seq: got cycles=%0d writes=%0d bad=%0d required 525 525 0", c_cyc, c_nw, c_bad); end
    n_cmp++; if (ch_ready !== 1'b1 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin n_fail++; $display("FAIL clear_done: got ready=%b cursor %0d,%0d required 1 0,0", ch_ready, cursor_row, cursor_col); end
    n_cmp++; if (screen_diff() !== 0) begin n_fail++; $display("FAIL clear_ram: got %0d differing bytes required 0", screen_diff()); end
  endtask

  task automatic test_put_char();
    push_m(8'h0A); push_m(8'h78); push_m(8'h79);
    push_m(8'h41);
    n_cmp++; if (p_nwr !== 1 || p_first_we !== 0 || p_busy !== 1) begin n_fail++; $display("FAIL put_timing: got writes=%0d first=%0d busy=%0d required 1 0 1", p_nwr, p_first_we, p_busy); end
    n_cmp++; if (p_addr !== 10'd18 || p_be !== 4'b0001 || p_wdata !== 32'h41414141) begin n_fail++; $display("FAIL put_write: got addr=%0d be=%b wdata=%h required 18 0001 41414141", p_addr, p_be, p_wdata); end
    n_cmp++; if (cursor_row !== 5'd1 || cursor_col !== 7'd3) begin n_fail++; $display("FAIL put_cursor: got %0d,%0d required 1,3", cursor_row, cursor_col); end
    push_m(8'h0D);
    n_cmp++; if (p_busy !== 0 || p_nwr !== 0 || cursor_col !== 7'd0 || cursor_row !== 5'd1) begin n_fail++; $display("FAIL cr: got busy=%0d writes=%0d cursor %0d,%0d required 0 0 1,0", p_busy, p_nwr, cursor_row, cursor_col); end
  endtask

  task automatic test_row_wrap();
    push_m(8'h0C);
    n_cmp++; if (p_busy !== 525 || p_nwr !== 525 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin n_fail++; $display("FAIL ff: got busy=%0d writes=%0d cursor %0d,%0d required 525 525 0,0", p_busy, p_nwr, cursor_row, cursor_col); end
    for (int i = 0; i < 70; i++) push_m(8'($urandom_range(32, 126)));
    n_cmp++; if (p_addr !== 10'd17 || p_be !== 4'b0010) begin n_fail++; $display("FAIL wrap_last_write: got addr=%0d be=%b required 17 0010", p_addr, p_be); end
    n_cmp++; if (cursor_row !== 5'd1 || cursor_col !== 7'd0) begin n_fail++; $display("FAIL wrap_cursor: got %0d,%0d required 1,0", cursor_row, cursor_col); end
    n_cmp++; if (screen_diff() !== 0) begin n_fail++; $display("FAIL wrap_ram: got %0d differing bytes required 0", screen_diff()); end
  endtask

  task automatic test_backspace();
    push_m(8'h0A); push_m(8'h0A);
    push_m(8'h08);
    n_cmp++; if (cursor_row !== 5'd2 || cursor_col !== 7'd69) begin n_fail++; $display("FAIL bs_wrap_cursor: got %0d,%0d required 2,69", cursor_row, cursor_col); end
    n_cmp++; if (p_nwr !== 1 || p_addr !== 10'd52 || p_be !== 4'b0010 || p_wdata !== 32'h20202020) begin n_fail++; $display("FAIL bs_wrap_write: got n=%0d addr=%0d be=%b wdata=%h required 1 52 0010 20202020", p_nwr, p_addr, p_be, p_wdata); end
    push_m(8'h0C); push_m(8'h71);
    push_m(8'h08);
    n_cmp++; if (p_nwr !== 1 || p_addr !== 10'd0 || p_be !== 4'b0001 || cursor_col !== 7'd0) begin n_fail++; $display("FAIL bs_col: got n=%0d addr=%0d be=%b col=%0d required 1 0 0001 0", p_nwr, p_addr, p_be, cursor_col); end
    push_m(8'h08);
    n_cmp++; if (p_nwr !== 0 || p_busy !== 0 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin n_fail++; $display("FAIL bs_origin: got n=%0d busy=%0d cursor %0d,%0d required 0 0 0,0", p_nwr, p_busy, cursor_row, cursor_col); end
    n_cmp++; if (screen_diff() !== 0) begin n_fail++; $display("FAIL bs_ram: got %0d differing bytes required 0", screen_diff()); end
  endtask

  task automatic test_scroll();
    logic [31:0] w;
    logic [7:0] old70, old2099;
    int blanks;
    push_m(8'h0C);
    for (int a = 0; a < NW; a++) begin
      for (int k = 0; k < 4; k++) begin
        w[8*k +: 8] = 8'($urandom_range(33, 126));
        screen[4*a + k] = w[8*k +: 8];
      end
      @(negedge clk); seed_we = 1'b1; seed_addr = 10'(a); seed_data = w;
    end
    @(negedge clk); seed_we = 1'b0;
    for (int i = 0; i < 29; i++) push_m(8'h0A);
    n_cmp++; if (cursor_row !== 5'd29 || cursor_col !== 7'd0) begin n_fail++; $display("FAIL scroll_pre_cursor: got %0d,%0d required 29,0", cursor_row, cursor_col); end
    old70 = screen[70];
    old2099 = screen[2099];
    push_m(8'h0A);
    n_cmp++; if (p_busy !== 4130 || p_nwr !== 2100 || p_overlap !== 0) begin n_fail++; $display("FAIL scroll_len: got busy=%0d writes=%0d overlap=%0d required 4130 2100 0", p_busy, p_nwr, p_overlap); end
    n_cmp++; if (cursor_row !== 5'd29 || cursor_col !== 7'd0) begin n_fail++; $display("FAIL scroll_cursor: got %0d,%0d required 29,0", cursor_row, cursor_col); end
    n_cmp++; if (ram_byte(0) !== old70 || ram_byte(2029) !== old2099) begin n_fail++; $display("FAIL scroll_move: got %h %h required %h %h", ram_byte(0), ram_byte(2029), old70, old2099); end
    blanks = 0;
    for (int b = 2030; b < NB; b++) if (ram_byte(b) === 8'h20) blanks++;
    n_cmp++; if (blanks !== 70) begin n_fail++; $display("FAIL scroll_blank_row: got %0d blank bytes required 70", blanks); end
    n_cmp++; if (screen_diff() !== 0) begin n_fail++; $display("FAIL scroll_ram: got %0d differing bytes required 0", screen_diff()); end
  endtask

  task automatic test_random();
    logic [7:0] c;
    int eb, ew, ovl;
    ovl = 0;
    for (int i = 0; i < 80; i++) begin
      c = rand_char();
      push(c);
      model_char(c, eb, ew);
      ovl += p_overlap;
      n_cmp++; if (p_timeout !== 1'b0 || p_busy !== eb || p_nwr !== ew) begin n_fail++; $display("FAIL rand_cost[%0d] ch=%h: got busy=%0d writes=%0d to=%0d required %0d %0d 0", i, c, p_busy, p_nwr, p_timeout, eb, ew); end
      n_cmp++; if (cursor_row !== 5'(mrow) || cursor_col !== 7'(mcol)) begin n_fail++; $display("FAIL rand_cursor[%0d] ch=%h: got %0d,%0d required %0d,%0d", i, c, cursor_row, cursor_col, mrow, mcol); end
    end
    n_cmp++; if (ovl !== 0) begin n_fail++; $display("FAIL rand_overlap: got %0d required 0", ovl); end
    n_cmp++; if (screen_diff() !== 0) begin n_fail++; $display("FAIL rand_ram: got %0d differing bytes required 0", screen_diff()); end
  endtask

  task automatic test_reset_mid_scroll();
    push_m(8'h0C);
    for (int i = 0; i < 29; i++) push_m(8'h0A);
    @(negedge clk); ch_valid = 1'b1; ch_data = 8'h0A; #2;
    @(negedge clk); ch_valid = 1'b0;
    repeat (1000) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_scroll_busy: got %b required 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0 || mem_re !== 1'b0 || mem_be !== 4'h0 || mem_addr !== 10'h0) begin n_fail++; $display("FAIL mid_rst_mem: got we=%b re=%b be=%h addr=%0d required 0 0 0 0", mem_we, mem_re, mem_be, mem_addr); end
    n_cmp++; if (ch_ready !== 1'b0 || busy !== 1'b1 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin n_fail++; $display("FAIL mid_rst_state: got ready=%b busy=%b cursor %0d,%0d required 0 1 0,0", ch_ready, busy, cursor_row, cursor_col); end
    reset = 1'b0; #2;
    watch_clear();
    model_blank_all();
    n_cmp++; if (c_cyc !== 525 || c_nw !== 525 || c_bad !== 0) begin n_fail++; $display("FAIL mid_rst_clear: got cycles=%0d writes=%0d bad=%0d required 525 525 0", c_cyc, c_nw, c_bad); end
    n_cmp++; if (ch_ready !== 1'b1 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin n_fail++; $display("FAIL mid_rst_done: got ready=%b cursor %0d,%0d required 1 0,0", ch_ready, cursor_row, cursor_col); end
    n_cmp++; if (screen_diff() !== 0) begin n_fail++; $display("FAIL mid_rst_ram: got %0d differing bytes required 0", screen_diff()); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_put_char();
    test_row_wrap();
    test_backspace();
    test_scroll();
    test_random();
    test_reset_mid_scroll();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/text_console_ctrl.md
# text_console_ctrl

Terminal-style writer for the 70x30 character VGA text buffer. It accepts a byte stream of ASCII characters and control codes through a valid/ready handshake and tracks the cursor. It writes characters into the word-organised text RAM that the VGA display path reads, one byte lane at a time. It also performs hardware scroll and clear-screen sequences, so the CPU side only ever pushes characters.

## Interface
Parameters:
- COLS, 70: characters per row.
- ROWS, 30: rows per screen.
- BLANK, 8'h20: fill character for clear and scroll.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- ch_valid  in  1  character offered.
- ch_data  in  8  ASCII character or control code.
- ch_ready  out  1  block can accept; equals (state==IDLE).
- mem_addr  out  10  word address into the text RAM = byte_addr[11:2].
- mem_wdata  out  32  write data; the byte is replicated on all four lanes for byte writes.
- mem_be  out  4  byte enables; bit k selects bits [8k+7:8k].
- mem_we  out  1  write strobe, one word per cycle.
- mem_re  out  1  read strobe.
- mem_rdata  in  32  read data, valid exactly 1 cycle after mem_re.
- cursor_row  out  5  current row, 0..ROWS-1.
- cursor_col  out  7  current column, 0..COLS-1.
- busy  out  1  high in any state other than IDLE.

## Operation
- Byte address mapping: byte_addr = row*COLS + col, 12 bits, range 0..2099.
  - Word address = byte_addr[11:2].
  - Lane = byte_addr[1:0]; byte N of a word sits at bits [8N+7:8N].
- States: CLEAR, IDLE, PUT, SCROLL_RD, SCROLL_WR, SCROLL_CLR.
- Reset values, held while reset=1:
  - state=CLEAR with pointer 0.
  - cursor 0,0.
  - mem_we=0, mem_re=0, mem_be=0, mem_addr=0.
  - ch_ready=0, busy=1.
- CLEAR:
  - One word write per cycle to words 0..524: be=4'hF, wdata={4{BLANK}}.
  - Then cursor is set to 0,0 and the block goes to IDLE.
- IDLE: a handshake occurs when ch_valid & ch_ready. The accepted byte is decoded as follows.
  - 0x20..0x7E (printable):
    - Go to PUT and write the byte at the cursor.
    - Then col+1. If col reaches COLS, col=0 and row+1.
    - If row reaches ROWS, row stays ROWS-1 and the block enters SCROLL_RD; otherwise it returns to IDLE.
  - 0x0A (LF):
    - col=0, row+1.
    - If row was ROWS-1, row stays ROWS-1 and the block enters SCROLL_RD; otherwise it stays in IDLE.
  - 0x0D (CR): col=0; stay in IDLE.
  - 0x08 (BS):
    - If col>0: col-1.
    - Else if row>0: row-1, col=COLS-1.
    - At 0,0: no change and no write.
    - When the cursor moved, go to PUT and write BLANK at the new position; the cursor is not advanced after that PUT.
  - 0x0C (FF): enter CLEAR; cursor becomes 0,0 when the clear completes.
  - Any other code: ignored, no memory access, stay in IDLE.
- Scroll: byte pointer p runs 0..(ROWS-1)*COLS-1 (0..2029).
  - SCROLL_RD: mem_re=1, addr=(p+COLS)>>2.
  - SCROLL_WR: select byte lane (p+COLS)[1:0] from mem_rdata, write it with addr=p>>2 and be=1<<p[1:0]; then p+1.
  - SCROLL_CLR: p runs 2030..2099, writing BLANK one byte per cycle.
  - Then the block returns to IDLE.
- Only one of mem_we / mem_re is ever high in a given cycle.

## Timing
- Printable character accepted in cycle N:
  - mem_we=1 in cycle N+1.
  - Cursor shows its new value in cycle N+2.
  - ch_ready=1 again in cycle N+2, unless a scroll follows.
- CR, LF without scroll, and ignored codes: the cursor updates in N+1 and ch_ready=1 in N+1.
- Scroll length: 2*2030 + 70 = 4130 cycles from the first SCROLL_RD to IDLE.
- Clear length: 525 cycles from the first write to IDLE.
  - After reset deasserts, the first CLEAR write happens in that same cycle.
  - ch_ready first rises 525 cycles later.
- Reset asserted in any state, including mid-scroll or mid-clear:
  - The next cycle shows the reset values.
  - Any partial operation is abandoned, and a full clear runs after release.
- ch_data is sampled only on the handshake. ch_valid may stay high across busy periods without effect.

## Test plan
- Reset release: 525 consecutive word writes to addresses 0..524 with be=F and wdata=32'h20202020, then ch_ready=1 and cursor 0,0.
- Push 'A' (0x41) at cursor row 1, col 2:
  - byte_addr 72, so one write with addr=18, be=4'b0001, wdata=32'h41414141.
  - Cursor then row 1, col 3.
- Push 70 printable characters starting at 0,0: the last write goes to byte 69 (addr=17, be=4'b0010), and the cursor ends at row 1, col 0.
- Cursor at row 29, push LF:
  - 4130-cycle scroll.
  - Check a pre-seeded RAM model: byte 70 is moved to byte 0, byte 2099 to byte 2029, and bytes 2030..2099 are all 0x20.
  - Cursor ends at row 29, col 0.
- BS at row 3, col 0: cursor moves to row 2, col 69 and 0x20 is written at byte 209 (addr=52, be=4'b0010). BS at 0,0: no write, cursor unchanged.
- Assert reset for 1 cycle in the middle of a scroll: outputs return to their reset values the next cycle, then a full clear runs and the cursor returns to 0,0.
